adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin arbiter that shares one 32-bit carry-lookahead adder (Carry_look_A_Head_Adder, instantiated internally) among NREQ requesters. Each requester offers an operand pair plus carry-in over a valid/ready handshake. The winner's operands go through the adder in the grant cycle, and the result is captured in a single-entry output register with valid/ready backpressure. The block sits between independent datapath clients and the shared adder, giving one add per cycle of throughput and one cycle of latency.

## Interface
- NREQ, 4, number of requesters; legal range 2..16; IDW = $clog2(NREQ)
- Clk  in  1  rising-edge clock, single clock domain
- Reset  in  1  synchronous, active-high reset
- Req_Valid  in  NREQ  bit i: requester i presents an operation
- Req_Ready  out  NREQ  bit i: requester i is granted this cycle; at most one bit high (one-hot or zero)
- Req_A  in  NREQ*32  operand A, requester i at [32*i+31:32*i]
- Req_B  in  NREQ*32  operand B, same packing
- Req_Cin  in  NREQ  carry-in per requester
- Rsp_Valid  out  1  output register holds a result
- Rsp_Ready  in  1  consumer accepts the result
- Rsp_Id  out  IDW  index of the requester that produced the result
- Rsp_Sum  out  32  A + B + Cin, modulo 2^32
- Rsp_Cout  out  1  carry out of bit 31
- Rsp_Ovf  out  1  signed overflow: A[31]==B[31] and Sum[31]!=A[31]
- Op_Count  out  32  count of results consumed (Rsp_Valid & Rsp_Ready); wraps from 0xFFFFFFFF to 0

## Operation
- Output register FSM has two states:
  - EMPTY: Rsp_Valid=0.
  - FULL: Rsp_Valid=1.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on a drain (Rsp_Ready=1) with no grant.
  - FULL→FULL either on a stall (Rsp_Ready=0; register holds) or on drain plus grant in the same cycle (register reloads).
- Can_Accept = !Reset & (EMPTY | Rsp_Ready).
- Arbitration:
  - Priority pointer Ptr (IDW bits) scans indices Ptr, Ptr+1, … modulo NREQ.
  - The first i with Req_Valid[i]=1 is selected.
  - Req_Ready[i] = Can_Accept & selected(i).
  - With no valid requester, Req_Ready=0.
- Grant (transfer) = Req_Valid[i] & Req_Ready[i]. On a grant:
  - the adder inputs are Req_A/Req_B/Req_Cin of i;
  - Sum, Cout, Ovf and Id=i are registered;
  - Ptr <= (i+1) mod NREQ.
- Ptr changes only on a grant. Non-power-of-two NREQ wraps from NREQ-1 to 0; Ptr never holds a value ≥ NREQ.
- Adder mux inputs are zero when there is no grant. Output registers load only on a grant.
- Req_Ready depends combinationally on Req_Valid and Rsp_Ready. Requesters must not make Req_Valid depend on Req_Ready. Once Req_Valid is asserted, it and the operands are held until the transfer.
- Rsp_* are stable while Rsp_Valid=1 and Rsp_Ready=0.
- Op_Count increments by 1 on each Rsp_Valid & Rsp_Ready cycle.

## Timing
- Reset (synchronous, checked at the Clk edge):
  - Rsp_Valid=0, Rsp_Id=0, Rsp_Sum=0, Rsp_Cout=0, Rsp_Ovf=0, Op_Count=0, Ptr=0, state EMPTY.
  - Req_Ready=0 in every cycle where Reset=1.
- Latency: a grant in cycle N gives Rsp_Valid=1 with that result in cycle N+1.
- Throughput: one grant per cycle while Rsp_Ready=1.
- Stall: while FULL and Rsp_Ready=0, Req_Ready=0 for all requesters.
- Drain plus grant in the same cycle: the old result is consumed, the new result appears in the next cycle, and Rsp_Valid stays high.
- Reset mid-operation: a held response is discarded (not delivered, not counted). An in-flight grant in the reset cycle does not occur.
- The adder path (mux → CLA → register) is a single-cycle combinational path.

## Test plan
- Single add: requester 2 sends A=0xFFFFFFFF, B=0x00000001, Cin=0, with Rsp_Ready=1. Required response, one cycle later:
  - Rsp_Valid=1, Rsp_Id=2, Rsp_Sum=0x00000000, Rsp_Cout=1, Rsp_Ovf=0;
  - Op_Count=1 after the drain.
- Overflow: A=0x7FFFFFFF, B=0x00000000, Cin=1 → Sum=0x80000000, Cout=0, Ovf=1.
- Round-robin: all 4 requesters valid continuously with Rsp_Ready=1 → grant order 0,1,2,3,0,1,…, one grant per cycle, Rsp_Id following the same sequence one cycle later.
- Sparse wrap: only requesters 1 and 3 valid, Ptr=2 → grants 3,1,3,1. With NREQ=3 and all valid, grant order is 0,1,2,0 (Ptr never 3).
- Backpressure: FULL with Rsp_Ready=0 for 3 cycles while requesters are valid → Req_Ready=0 and Rsp_* unchanged for all 3 cycles. On the cycle Rsp_Ready=1, a new grant occurs, and the next cycle shows the new result with Op_Count incremented by 1.
- Reset mid-operation: FULL with Rsp_Ready=0, then Reset=1 for one cycle → next cycle Rsp_Valid=0, Op_Count=0, and the first grant after reset goes to requester 0 when all are valid.

Source files
------------

// File: rtl/Carry_look_A_Head_Adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module Carry_look_A_Head_Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    // Carries inside each group are expanded from that group's carry-in.
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    c[32] = gc[8];
    sum   = p ^ c[31:0];
    cout  = c[32];
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit CLA among NREQ requesters, with a single-entry
// valid/ready result register.
module adder_share_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req_Valid,
  output logic [NREQ-1:0]      Req_Ready,
  input  logic [NREQ*32-1:0]   Req_A,
  input  logic [NREQ*32-1:0]   Req_B,
  input  logic [NREQ-1:0]      Req_Cin,
  output logic                 Rsp_Valid,
  input  logic                 Rsp_Ready,
  output logic [IDW-1:0]       Rsp_Id,
  output logic [31:0]          Rsp_Sum,
  output logic                 Rsp_Cout,
  output logic                 Rsp_Ovf,
  output logic [31:0]          Op_Count
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_nxt;
  logic [IDW-1:0] id_q;
  logic [31:0]    sum_q;
  logic           cout_q;
  logic           ovf_q;
  logic [31:0]    op_count_q;

  logic [31:0]    a_arr [NREQ];
  logic [31:0]    b_arr [NREQ];
  logic           can_accept;
  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] cand;
  logic [IDW:0]   idx_w;
  logic           grant;
  logic [31:0]    add_a, add_b, add_sum;
  logic           add_cin, add_cout, add_ovf;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = Req_A[32*i +: 32];
    assign b_arr[i] = Req_B[32*i +: 32];
  end

  assign can_accept = !Reset && ((state_q == StEmpty) || Rsp_Ready);

  // Scan Ptr, Ptr+1, ... modulo NREQ; the first valid index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NREQ)) begin
        idx_w = idx_w - (IDW+1)'(NREQ);
      end
      cand = idx_w[IDW-1:0];
      if (!sel_found && Req_Valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign grant     = can_accept && sel_found;
  assign Req_Ready = grant ? (NREQ'(1) << sel_idx) : '0;
  assign ptr_nxt   = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;

  assign add_a   = grant ? a_arr[sel_idx] : '0;
  assign add_b   = grant ? b_arr[sel_idx] : '0;
  assign add_cin = grant ? Req_Cin[sel_idx] : 1'b0;

  Carry_look_A_Head_Adder u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant) state_d = StFull;
      StFull:  if (!grant && Rsp_Ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StEmpty;
      ptr_q      <= '0;
      id_q       <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q  <= ptr_nxt;
        id_q   <= sel_idx;
        sum_q  <= add_sum;
        cout_q <= add_cout;
        ovf_q  <= add_ovf;
      end
      if ((state_q == StFull) && Rsp_Ready) begin
        op_count_q <= op_count_q + 32'd1;
      end
    end
  end

  assign Rsp_Valid = (state_q == StFull);
  assign Rsp_Id    = id_q;
  assign Rsp_Sum   = sum_q;
  assign Rsp_Cout  = cout_q;
  assign Rsp_Ovf   = ovf_q;
  assign Op_Count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized scoreboard bench for adder_share_arbiter against a transaction-level model.
module tb_adder_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready, req_cin;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_sum, op_count;
  logic                rsp_cout, rsp_ovf;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NREQ(NREQ)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Req_Valid (req_valid),
    .Req_Ready (req_ready),
    .Req_A     (req_a),
    .Req_B     (req_b),
    .Req_Cin   (req_cin),
    .Rsp_Valid (rsp_valid),
    .Rsp_Ready (rsp_ready),
    .Rsp_Id    (rsp_id),
    .Rsp_Sum   (rsp_sum),
    .Rsp_Cout  (rsp_cout),
    .Rsp_Ovf   (rsp_ovf),
    .Op_Count  (op_count)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    sum;
    logic           cout;
    logic           ovf;
  } rsp_t;

  int          compared   = 0;
  int          mismatched = 0;
  rsp_t        exp_q[$];
  bit          m_full  = 1'b0;
  int          m_ptr   = 0;
  logic [31:0] m_count = '0;
  int          m_gnt   = -1;

  bit              auto_req = 1'b0;
  bit              rand_rdy = 1'b0;
  int              req_pct  = 100;
  logic [NREQ-1:0] drv_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks occupancy, pointer and count; predicts grants and results.
  always @(negedge clk) begin : model
    int w;
    int j;
    logic [NREQ-1:0] er;
    logic [31:0] a, b;
    logic [32:0] full;
    rsp_t r;
    if (reset) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      m_full  = 1'b0;
      m_ptr   = 0;
      m_count = '0;
      exp_q.delete();
      m_gnt   = -1;
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      chk("op_count", 64'(op_count), 64'(m_count));
      w = -1;
      if (!m_full || rsp_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[j]) w = j;
        end
      end
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (m_full && rsp_ready) m_count = m_count + 1;
      if (w >= 0) begin
        a      = req_a[32*w +: 32];
        b      = req_b[32*w +: 32];
        full   = 33'(a) + 33'(b) + 33'(req_cin[w]);
        r.id   = IDW'(w);
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
        exp_q.push_back(r);
        m_ptr  = (w + 1) % NREQ;
        m_full = 1'b1;
      end else if (rsp_ready) begin
        m_full = 1'b0;
      end
      m_gnt = w;
    end
  end

  // Monitor: compares whatever the DUT presents against the oldest expected result.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = exp_q[0];
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
  endtask

  // One clock: retire the granted request, then optionally refill and randomize ready.
  task automatic step();
    @(posedge clk);
    #1;
    if (m_gnt >= 0) req_valid[m_gnt] = 1'b0;
    if (auto_req) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && drv_mask[i] && ($urandom_range(99) < req_pct))
          new_req(i, pick(), pick(), 1'($urandom_range(1)));
      end
    end
    if (rand_rdy) rsp_ready = ($urandom_range(99) < 60);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_sum", 64'(rsp_sum), 64'd0);
    chk("rst_cout", 64'(rsp_cout), 64'd0);
    chk("rst_ovf", 64'(rsp_ovf), 64'd0);

    // Single add with carry out, then signed overflow.
    rsp_ready = 1'b1;
    new_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    repeat (3) step();
    new_req(0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (3) step();

    // All requesters continuously valid.
    auto_req = 1'b1;
    req_pct  = 100;
    drv_mask = 4'b1111;
    repeat (12) step();

    // Drain, steer the pointer to 2, then only requesters 1 and 3.
    drv_mask = '0;
    for (int n = 0; n < 10 && req_valid != '0; n++) step();
    new_req(1, pick(), pick(), 1'b0);
    step();
    drv_mask = 4'b1010;
    repeat (6) step();

    // Backpressure for three cycles with everyone waiting.
    drv_mask  = 4'b1111;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (3) step();

    // Reset while a stalled result is held.
    rsp_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();

    // Random traffic with random backpressure.
    req_pct  = 50;
    rand_rdy = 1'b1;
    repeat (400) step();

    // Quiesce and empty the output register.
    auto_req  = 1'b0;
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) step();
    @(negedge clk);
    chk("end_rsp_valid", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
